// File: rtl/top_pkg.sv
// Shared definitions for the boot-configuration controller: command and
// reply bytes, the command FSM state type and the UART parity helper.
package top_pkg;

    localparam logic [7:0] CMD_SET = 8'h53;  // 'S': set configuration word
    localparam logic [7:0] CMD_GET = 8'h43;  // 'C': read configuration word
    localparam logic [7:0] RPL_OK  = 8'h4B;  // 'K': set accepted
    localparam logic [7:0] RPL_BAD = 8'h3F;  // '?': unknown command

    // Heartbeat LED toggles every 2**HB_BITS clocks
    localparam int HB_BITS = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S_HI = 2'd1,
        ST_S_LO = 2'd2
    } cmd_state_t;

    // Parity bit that makes the total number of ones even (odd = 0) or odd (odd = 1)
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_core.sv
// Bit-level UART receiver and transmitter sharing one frame format:
// start bit, 8 data bits in FIRST_BIT order, optional parity, 1 stop bit.
//
// Handshakes: rx_valid is a one-clock pulse with rx_data stable during it
// (no back-pressure; the consumer must take it). On the transmit side a byte
// transfers on a clock where tx_valid and tx_ready are both high; tx_data must
// be stable while tx_valid is high and tx_valid never depends on tx_ready.
module uart_core import top_pkg::*; #(
    parameter int    CLOCK     = 50_000_000,
    parameter int    BAUD      = 115_200,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd
);

    localparam int   BIT     = CLOCK / BAUD;
    localparam int   HALF    = BIT / 2;
    localparam int   CW      = $clog2(BIT);
    localparam logic PAR_EN  = (PARITY != "NO");
    localparam logic PAR_ODD = (PARITY == "ODD");
    localparam logic MSB     = (FIRST_BIT == "MSB");
    // Bits shifted out after the start bit: data, optional parity, stop
    localparam logic [3:0] TX_BITS = PAR_EN ? 4'd10 : 4'd9;

    logic          rxd_s1, rxd_s2, rxd_s3;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_idx;
    logic [7:0]    rx_sh;
    logic          rx_par;

    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_left;
    logic [9:0]    tx_sh;
    logic [7:0]    tx_ord;

    // Shift register holds data in natural bit order for both bit orders
    assign rx_data  = rx_sh;
    assign tx_ready = !tx_busy;

    // Put the first bit on the wire into tx_ord[0]
    always_comb begin
        tx_ord = tx_data;
        if (MSB) begin
            for (int i = 0; i < 8; i++) tx_ord[i] = tx_data[7-i];
        end
    end

    // Receiver: synchroniser, falling-edge start detect, mid-bit sampling
    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        rx_err   <= 1'b0;
        rx_start <= 1'b0;
        if (rst) begin
            rxd_s1  <= 1'b1;
            rxd_s2  <= 1'b1;
            rxd_s3  <= 1'b1;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_idx  <= '0;
            rx_sh   <= '0;
            rx_par  <= 1'b0;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
            if (!rx_busy) begin
                if (rxd_s3 && !rxd_s2) begin
                    rx_busy  <= 1'b1;
                    rx_cnt   <= CW'(HALF - 1);
                    rx_idx   <= '0;
                    rx_start <= 1'b1;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= CW'(BIT - 1);
                rx_idx <= rx_idx + 4'd1;
                if (rx_idx == 4'd0) begin
                    // Line back high at mid start bit: glitch, not a frame
                    if (rxd_s2) rx_busy <= 1'b0;
                end else if (rx_idx <= 4'd8) begin
                    if (MSB) rx_sh <= {rx_sh[6:0], rxd_s2};
                    else     rx_sh <= {rxd_s2, rx_sh[7:1]};
                end else if (PAR_EN && rx_idx == 4'd9) begin
                    rx_par <= rxd_s2;
                end else begin
                    rx_busy <= 1'b0;
                    if (rxd_s2 && (!PAR_EN || rx_par == parity_bit(rx_sh, PAR_ODD)))
                        rx_valid <= 1'b1;
                    else
                        rx_err <= 1'b1;
                end
            end
        end
    end

    // Transmitter: load a whole frame, shift one bit per bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_left <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (tx_valid) begin
                tx_busy <= 1'b1;
                txd     <= 1'b0;
                tx_cnt  <= CW'(BIT - 1);
                tx_left <= TX_BITS;
                tx_sh   <= {1'b1, (PAR_EN ? parity_bit(tx_data, PAR_ODD) : 1'b1), tx_ord};
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
        end else begin
            tx_cnt <= CW'(BIT - 1);
            if (tx_left == 4'd0) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                txd     <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_left <= tx_left - 4'd1;
            end
        end
    end

endmodule

// File: rtl/top.sv
// Boot-image configuration controller: UART commands set or read a 16-bit
// configuration word; every completed command is answered on the TX line.
module top import top_pkg::*; #(
    parameter int    CLOCK      = 50_000_000,
    parameter int    BAUD       = 115_200,
    parameter string PARITY     = "NO",
    parameter string FIRST_BIT  = "LSB",
    parameter int    NUMBER     = 256,
    parameter int    RX_TIMEOUT = 10
) (
    input  logic       inclk,
    input  logic       rxd_uart,
    output logic       txd_uart,
    output logic [4:0] led
);

    localparam int AW      = $clog2(NUMBER);
    localparam int TO_CLKS = RX_TIMEOUT * 10 * (CLOCK / BAUD);
    localparam int TW      = $clog2(TO_CLKS + 1);

    // Power-on reset: configuration loads zero into every flop, so the
    // counter runs from 0 and rst stays high for the first 16 clocks.
    logic [4:0] por_cnt;
    logic       rst;
    assign rst = !por_cnt[4];

    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_err, rx_start, tx_valid, tx_ready;

    logic [7:0]  fifo_mem [NUMBER];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full, push, pop, drop;
    logic [7:0]    fifo_head;

    logic [7:0] rb [4];
    logic [2:0] rb_len, rb_rd;
    logic       reply_pending, reply_busy;

    cmd_state_t  state_q, state_d;
    logic [7:0]  cfg_hi;
    logic [15:0] cfg_word;
    logic        cfg_hi_we, cfg_we, rep_load, cmd_done;
    logic [2:0]  rep_n;
    logic [7:0]  rep0, rep1, rep2;

    logic [TW-1:0] to_cnt;
    logic          to_fire;

    logic                led_cmd, err_flag, hb;
    logic [HB_BITS-1:0]  hb_cnt;

    uart_core #(
        .CLOCK     (CLOCK),
        .BAUD      (BAUD),
        .PARITY    (PARITY),
        .FIRST_BIT (FIRST_BIT)
    ) u_uart (
        .clk      (inclk),
        .rst      (rst),
        .rxd      (rxd_uart),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_start (rx_start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd_uart)
    );

    // Power-on reset counter, saturates once reset is released
    always_ff @(posedge inclk) begin
        if (!por_cnt[4]) por_cnt <= por_cnt + 5'd1;
    end

    // A full FIFO still accepts a byte on the clock it is also popped
    assign fifo_full = (fifo_cnt == (AW+1)'(NUMBER));
    assign push      = rx_valid && (!fifo_full || pop);
    assign drop      = rx_valid && fifo_full && !pop;
    assign fifo_head = fifo_mem[rd_ptr];

    // FIFO storage
    always_ff @(posedge inclk) begin
        if (push) fifo_mem[wr_ptr] <= rx_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge inclk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
        end
    end

    // Reply buffer is only loaded when empty, so it restarts at index 0
    assign reply_pending = (rb_rd != rb_len);
    assign reply_busy    = reply_pending || !tx_ready;
    assign tx_valid      = reply_pending;
    assign tx_data       = rb[rb_rd[1:0]];

    // Reply buffer load and drain
    always_ff @(posedge inclk) begin
        if (rst) begin
            rb_len <= '0;
            rb_rd  <= '0;
            for (int i = 0; i < 4; i++) rb[i] <= '0;
        end else if (rep_load) begin
            rb[0]  <= rep0;
            rb[1]  <= rep1;
            rb[2]  <= rep2;
            rb[3]  <= '0;
            rb_len <= rep_n;
            rb_rd  <= '0;
        end else if (tx_valid && tx_ready) begin
            rb_rd <= rb_rd + 3'd1;
        end
    end

    // Inter-byte timeout: restarts on each start bit, saturates at the limit
    assign to_fire = (to_cnt == TW'(TO_CLKS));
    always_ff @(posedge inclk) begin
        if (rst || rx_start) to_cnt <= '0;
        else if (!to_fire)   to_cnt <= to_cnt + TW'(1);
    end

    // Command FSM state register and configuration word
    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cfg_hi   <= '0;
            cfg_word <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_hi_we) cfg_hi   <= fifo_head;
            if (cfg_we)    cfg_word <= {cfg_hi, fifo_head};
        end
    end

    // Command decode: one FIFO byte per clock, held off while a reply is pending
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cfg_hi_we = 1'b0;
        cfg_we    = 1'b0;
        rep_load  = 1'b0;
        rep_n     = 3'd0;
        rep0      = 8'h00;
        rep1      = 8'h00;
        rep2      = 8'h00;
        cmd_done  = 1'b0;
        if (fifo_cnt != '0 && !reply_busy) begin
            pop = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_head == CMD_SET) begin
                        state_d = ST_S_HI;
                    end else if (fifo_head == CMD_GET) begin
                        rep_load = 1'b1;
                        rep_n    = 3'd3;
                        rep0     = CMD_GET;
                        rep1     = cfg_word[15:8];
                        rep2     = cfg_word[7:0];
                        cmd_done = 1'b1;
                    end else begin
                        rep_load = 1'b1;
                        rep_n    = 3'd1;
                        rep0     = RPL_BAD;
                        cmd_done = 1'b1;
                    end
                end
                ST_S_HI: begin
                    cfg_hi_we = 1'b1;
                    state_d   = ST_S_LO;
                end
                ST_S_LO: begin
                    cfg_we   = 1'b1;
                    rep_load = 1'b1;
                    rep_n    = 3'd1;
                    rep0     = RPL_OK;
                    cmd_done = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_fire) begin
            state_d = ST_IDLE;
        end
    end

    // Status LEDs: command toggle, sticky error, heartbeat
    always_ff @(posedge inclk) begin
        if (rst) begin
            led_cmd  <= 1'b0;
            err_flag <= 1'b0;
            hb       <= 1'b0;
            hb_cnt   <= '0;
        end else begin
            if (cmd_done)          led_cmd  <= !led_cmd;
            if (rx_err || drop)    err_flag <= 1'b1;
            hb_cnt <= hb_cnt + HB_BITS'(1);
            if (&hb_cnt)           hb <= !hb;
        end
    end

    assign led = {hb, err_flag, led_cmd, cfg_word[9:8]};

endmodule

// File: tb/tb_top.sv
// Bench for top: three instances (LSB/no parity, even parity, MSB first),
// 100 MHz clock, 10 Mbit/s line, so one bit period is 10 clocks.
module tb_top;
    import top_pkg::*;

    localparam int BITC = 10;

    logic clk = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic txd_a, txd_b, txd_c;
    logic [4:0] led_a, led_b, led_c;

    int checks = 0;
    int errors = 0;
    int mon_err = 0;
    logic [7:0] got_a[$], got_b[$], got_c[$];
    logic [7:0] exp_q[$];
    logic [7:0] b;

    always #5 clk = ~clk;

    top #(.CLOCK(100_000_000), .BAUD(10_000_000), .PARITY("NO"), .FIRST_BIT("LSB"),
          .NUMBER(16), .RX_TIMEOUT(10))
    dut_a (.inclk(clk), .rxd_uart(rxd_a), .txd_uart(txd_a), .led(led_a));

    top #(.CLOCK(100_000_000), .BAUD(10_000_000), .PARITY("EVEN"), .FIRST_BIT("LSB"),
          .NUMBER(16), .RX_TIMEOUT(10))
    dut_b (.inclk(clk), .rxd_uart(rxd_b), .txd_uart(txd_b), .led(led_b));

    top #(.CLOCK(100_000_000), .BAUD(10_000_000), .PARITY("NO"), .FIRST_BIT("MSB"),
          .NUMBER(16), .RX_TIMEOUT(10))
    dut_c (.inclk(clk), .rxd_uart(rxd_c), .txd_uart(txd_c), .led(led_c));

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic v);
        case (sel)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic send_byte(input int sel, input logic [7:0] data, input bit par_en,
                             input bit msb, input bit bad_par, input bit stop_val,
                             input int gap_bits);
        @(negedge clk);
        drive(sel, 1'b0);
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, msb ? data[7-i] : data[i]);
            repeat (BITC) @(negedge clk);
        end
        if (par_en) begin
            drive(sel, (^data) ^ bad_par);
            repeat (BITC) @(negedge clk);
        end
        drive(sel, stop_val);
        repeat (BITC) @(negedge clk);
        drive(sel, 1'b1);
        repeat (gap_bits * BITC) @(negedge clk);
    endtask

    function automatic logic txd_of(input int sel);
        case (sel)
            0: return txd_a;
            1: return txd_b;
            default: return txd_c;
        endcase
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0: return got_a.size();
            1: return got_b.size();
            default: return got_c.size();
        endcase
    endfunction

    task automatic wait_q(input int sel, input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (qsize(sel) >= n) break;
            @(negedge clk);
        end
    endtask

    // ---------------- TX line monitors ----------------
    task automatic rx_frame(input int sel, input bit par_en, input bit msb,
                            output logic [7:0] data, output bit bad);
        logic v;
        bad  = 1'b0;
        data = 8'h00;
        repeat (BITC / 2) @(negedge clk);
        if (txd_of(sel) !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (BITC) @(negedge clk);
            v = txd_of(sel);
            if (msb) data[7-i] = v;
            else     data[i]   = v;
        end
        if (par_en) begin
            repeat (BITC) @(negedge clk);
            if (txd_of(sel) !== (^data)) bad = 1'b1;
        end
        repeat (BITC) @(negedge clk);
        if (txd_of(sel) !== 1'b1) bad = 1'b1;
    endtask

    always begin : mon_a
        logic [7:0] d; bit bad;
        @(negedge txd_a);
        rx_frame(0, 1'b0, 1'b0, d, bad);
        got_a.push_back(d);
        if (bad) mon_err++;
    end

    always begin : mon_b
        logic [7:0] d; bit bad;
        @(negedge txd_b);
        rx_frame(1, 1'b1, 1'b0, d, bad);
        got_b.push_back(d);
        if (bad) mon_err++;
    end

    always begin : mon_c
        logic [7:0] d; bit bad;
        @(negedge txd_c);
        rx_frame(2, 1'b0, 1'b1, d, bad);
        got_c.push_back(d);
        if (bad) mon_err++;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({txd_a, txd_b, txd_c} !== 3'b111) begin
            errors++; $display("FAIL reset_txd: got %b expected 111", {txd_a, txd_b, txd_c});
        end
        checks++;
        if ({led_a, led_b, led_c} !== 15'd0) begin
            errors++; $display("FAIL reset_led: got %h expected 0000", {led_a, led_b, led_c});
        end
        repeat (20) @(negedge clk);
        checks++;
        if (txd_a !== 1'b1 || led_a !== 5'b0) begin
            errors++; $display("FAIL post_reset_idle: txd %b led %b expected 1 00000", txd_a, led_a);
        end
        checks++;
        if (dut_a.state_q !== ST_IDLE || dut_a.cfg_word !== 16'h0000) begin
            errors++; $display("FAIL post_reset_state: state %0d cfg %h expected 0 0000",
                               dut_a.state_q, dut_a.cfg_word);
        end
    endtask

    task automatic test_set_word();
        send_byte(0, 8'h53, 0, 0, 0, 1, 10);
        send_byte(0, 8'h04, 0, 0, 0, 1, 10);
        send_byte(0, 8'h93, 0, 0, 0, 1, 10);
        wait_q(0, 1, 600);
        checks++;
        if (got_a.size() == 0) begin
            errors++; $display("FAIL set_reply: no byte, expected 4b");
        end else begin
            b = got_a.pop_front();
            if (b !== 8'h4B) begin errors++; $display("FAIL set_reply: got %h expected 4b", b); end
        end
        checks++;
        if (dut_a.cfg_word !== 16'h0493) begin
            errors++; $display("FAIL set_cfg_word: got %h expected 0493", dut_a.cfg_word);
        end
        checks++;
        if (led_a[2:0] !== 3'b100) begin
            errors++; $display("FAIL set_led: got %b expected 100", led_a[2:0]);
        end
    endtask

    task automatic test_get_word();
        send_byte(0, 8'h43, 0, 0, 0, 1, 10);
        wait_q(0, 3, 800);
        exp_q = {};
        exp_q.push_back(8'h43); exp_q.push_back(8'h04); exp_q.push_back(8'h93);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_a.size() == 0) begin
                errors++; $display("FAIL get_reply[%0d]: no byte, expected %h", i, exp_q[i]);
            end else begin
                b = got_a.pop_front();
                if (b !== exp_q[i]) begin
                    errors++; $display("FAIL get_reply[%0d]: got %h expected %h", i, b, exp_q[i]);
                end
            end
        end
        checks++;
        if (led_a[2] !== 1'b0) begin
            errors++; $display("FAIL get_led2: got %b expected 0", led_a[2]);
        end
    endtask

    task automatic test_timeout();
        send_byte(0, 8'h53, 0, 0, 0, 1, 10);
        send_byte(0, 8'h01, 0, 0, 0, 1, 120);
        checks++;
        if (got_a.size() != 0 || dut_a.state_q !== ST_IDLE) begin
            errors++; $display("FAIL timeout_abort: replies %0d state %0d expected 0 0",
                               got_a.size(), dut_a.state_q);
        end
        send_byte(0, 8'h43, 0, 0, 0, 1, 10);
        wait_q(0, 3, 800);
        exp_q = {};
        exp_q.push_back(8'h43); exp_q.push_back(8'h04); exp_q.push_back(8'h93);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_a.size() == 0) begin
                errors++; $display("FAIL timeout_get[%0d]: no byte, expected %h", i, exp_q[i]);
            end else begin
                b = got_a.pop_front();
                if (b !== exp_q[i]) begin
                    errors++; $display("FAIL timeout_get[%0d]: got %h expected %h", i, b, exp_q[i]);
                end
            end
        end
        checks++;
        if (dut_a.cfg_word !== 16'h0493 || led_a[2] !== 1'b1) begin
            errors++; $display("FAIL timeout_cfg: cfg %h led2 %b expected 0493 1",
                               dut_a.cfg_word, led_a[2]);
        end
    endtask

    task automatic test_unknown();
        send_byte(0, 8'h55, 0, 0, 0, 1, 10);
        wait_q(0, 1, 600);
        checks++;
        if (got_a.size() == 0) begin
            errors++; $display("FAIL unknown_reply: no byte, expected 3f");
        end else begin
            b = got_a.pop_front();
            if (b !== 8'h3F) begin errors++; $display("FAIL unknown_reply: got %h expected 3f", b); end
        end
        checks++;
        if (led_a[3:2] !== 2'b00) begin
            errors++; $display("FAIL unknown_led: got %b expected 00", led_a[3:2]);
        end
    endtask

    task automatic test_stop_error();
        send_byte(0, 8'h43, 0, 0, 0, 0, 30);
        checks++;
        if (got_a.size() != 0) begin
            errors++; $display("FAIL stop_err_reply: got %0d bytes expected 0", got_a.size());
        end
        checks++;
        if (led_a[3] !== 1'b1) begin
            errors++; $display("FAIL stop_err_led3: got %b expected 1", led_a[3]);
        end
    endtask

    task automatic test_parity();
        send_byte(1, 8'h43, 1, 0, 1, 1, 30);
        checks++;
        if (got_b.size() != 0 || led_b[3] !== 1'b1) begin
            errors++; $display("FAIL parity_bad: bytes %0d led3 %b expected 0 1", got_b.size(), led_b[3]);
        end
        send_byte(1, 8'h43, 1, 0, 0, 1, 10);
        wait_q(1, 3, 800);
        exp_q = {};
        exp_q.push_back(8'h43); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_b.size() == 0) begin
                errors++; $display("FAIL parity_good[%0d]: no byte, expected %h", i, exp_q[i]);
            end else begin
                b = got_b.pop_front();
                if (b !== exp_q[i]) begin
                    errors++; $display("FAIL parity_good[%0d]: got %h expected %h", i, b, exp_q[i]);
                end
            end
        end
        checks++;
        if (led_b[2] !== 1'b1) begin
            errors++; $display("FAIL parity_led2: got %b expected 1", led_b[2]);
        end
    endtask

    task automatic test_msb();
        send_byte(2, 8'h53, 0, 1, 0, 1, 10);
        send_byte(2, 8'h03, 0, 1, 0, 1, 10);
        send_byte(2, 8'h00, 0, 1, 0, 1, 10);
        wait_q(2, 1, 600);
        send_byte(2, 8'h43, 0, 1, 0, 1, 10);
        wait_q(2, 4, 800);
        exp_q = {};
        exp_q.push_back(8'h4B); exp_q.push_back(8'h43);
        exp_q.push_back(8'h03); exp_q.push_back(8'h00);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_c.size() == 0) begin
                errors++; $display("FAIL msb_reply[%0d]: no byte, expected %h", i, exp_q[i]);
            end else begin
                b = got_c.pop_front();
                if (b !== exp_q[i]) begin
                    errors++; $display("FAIL msb_reply[%0d]: got %h expected %h", i, b, exp_q[i]);
                end
            end
        end
        checks++;
        if (led_c[1:0] !== 2'b11 || dut_c.cfg_word !== 16'h0300) begin
            errors++; $display("FAIL msb_cfg: led %b cfg %h expected 11 0300", led_c[1:0], dut_c.cfg_word);
        end
    endtask

    task automatic test_frames();
        repeat (50) @(negedge clk);
        checks++;
        if (mon_err != 0) begin
            errors++; $display("FAIL tx_framing: %0d malformed frames expected 0", mon_err);
        end
        checks++;
        if (got_a.size() + got_b.size() + got_c.size() != 0) begin
            errors++; $display("FAIL tx_extra: %0d unexpected bytes expected 0",
                               got_a.size() + got_b.size() + got_c.size());
        end
    endtask

    initial begin
        test_reset();
        test_set_word();
        test_get_word();
        test_timeout();
        test_unknown();
        test_stop_error();
        test_parity();
        test_msb();
        test_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
